controlador_sequenciador: RTL and testbench
===========================================

CONTROLADOR_SEQUENCIADOR -- requirements
Module: controlador_sequenciador

Interface
REQ-001 SHALL have parameter OPC_W, default 4, meaning opcode width taken from the instruction register high nibble.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port run, input, 1: 1 = advance the T-state each cycle; 0 = hold the current T-state.
REQ-005 SHALL have port opcode, input, OPC_W, instruction register high nibble, valid from T4.
REQ-006 SHALL have port t_state, output, 6, one-hot T1..T6 (bit0 = T1).
REQ-007 SHALL have ports Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, output, 1 each, active-high control word.
REQ-008 SHALL have port hlt, output, 1: 1 = machine halted.

Function
REQ-009 SHALL sequence T1->T2->...->T6->T1, one step per clk edge while run=1 and hlt=0.
REQ-010 SHALL decode the control word combinationally from the registered t_state, hlt and opcode; no added latency.
REQ-011 Fetch, all opcodes:
- T1: Ep, Lm.
- T2: Cp.
- T3: CE, Li.
REQ-012 LDA (0000):
- T4: Ei, Lm.
- T5: CE, La.
- T6: none.
REQ-013 ADD (0001):
- T4: Ei, Lm.
- T5: CE, Lb.
- T6: Eu, La, Su=0.
REQ-014 SUB (0010): as ADD, but T6 asserts Eu, La, Su=1.
REQ-015 OUT (1110):
- T4: Ea, Lo.
- T5, T6: none.
REQ-016 HLT (1111): at T4, set the registered hlt flag on the next edge; from then on, t_state freezes at T4 and all control bits are 0 until reset.
REQ-017 Undefined opcodes SHALL execute as NOP: T4-T6 all control bits 0; sequencing continues.
REQ-018 Su SHALL be 1 only in SUB T6, and Eu only in ADD/SUB T6, so the adder/subtractor drives the bus only in that state.
REQ-019 At most one bus driver among Ep, CE, Ei, Ea, Eu SHALL be asserted in any cycle.
REQ-020 While run=0: t_state held, all control bits forced 0, hlt held.
REQ-021 When run=1 resumes, the held state SHALL emit its control word in that same cycle and advance on the following edge.
REQ-022 Opcode changes outside T4-T6 SHALL have no effect on outputs.

Reset
REQ-023 rst=1 at an edge SHALL set t_state=T1 and hlt=0, regardless of run or the current state, including mid-instruction and halted.
REQ-024 While rst=1, all control bits SHALL be 0.
REQ-025 In the first cycle after rst falls, with run=1, the outputs SHALL show the T1 word (Ep, Lm).
REQ-026 rst SHALL take precedence over run and hlt.

Structure
REQ-027 Shared package sap1_pkg SHALL hold:
- opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT;
- T-state one-hot constants T1..T6;
- control-word bit indices.
REQ-028 One sub-module, contador_anel, SHALL implement the 6-bit one-hot ring counter with rst, run and a freeze input; decode stays in the top module.

Verification
REQ-029 rst pulse, run=1, opcode=0000: t_state 000001,000010,...,100000,000001; control matches REQ-011/012 each cycle.
REQ-030 opcode=0010, full cycle: T6 shows Eu=1, Su=1, La=1; in ADD (0001) the same T6 shows Su=0.
REQ-031 opcode=1111: after T4, hlt=1, t_state stays 001000 with all controls 0 for 20 cycles; then rst -> T1, hlt=0.
REQ-032 run=0 held for 3 cycles at T5 of ADD: t_state=010000 and all controls 0 throughout; on run=1, CE, Lb appear, then T6.
REQ-033 rst asserted at T5 of SUB: next cycle controls 0; after release, T1 (Ep, Lm), with no Eu seen.
REQ-034 opcode=0111 (undefined): T4-T6 all controls 0; the next fetch is normal.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller/sequencer: opcodes, one-hot
// T-states and the bit positions of the control word.
package sap1_pkg;

    // Opcodes (instruction register high nibble)
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // One-hot T-states, bit0 = T1
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // Control word layout, MSB first: Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo
    localparam int CW_W  = 12;
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/controlador_sequenciador_contador_anel.sv
// Six-position one-hot ring counter producing the T-state. Advances one
// position per edge while run=1 and freeze=0; reset returns it to T1.
module contador_anel
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       freeze,
    output logic [5:0] t_state
);

    logic [5:0] ring_q;
    logic [5:0] ring_d;

    // Next ring value: rotate left when allowed to advance, otherwise hold
    always_comb begin
        ring_d = ring_q;
        if (run && !freeze) begin
            ring_d = {ring_q[4:0], ring_q[5]};
        end
    end

    // Ring register with synchronous reset to T1
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_q <= T1;
        end else begin
            ring_q <= ring_d;
        end
    end

    assign t_state = ring_q;

endmodule

// File: rtl/controlador_sequenciador.sv
// SAP-1 controller/sequencer: ring-counter T-state, registered halt flag
// and a purely combinational control-word decode of (t_state, hlt, opcode).
module controlador_sequenciador
    import sap1_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [OPC_W-1:0] opcode,
    output logic [5:0]       t_state,
    output logic             Cp,
    output logic             Ep,
    output logic             Lm,
    output logic             CE,
    output logic             Li,
    output logic             Ei,
    output logic             La,
    output logic             Ea,
    output logic             Su,
    output logic             Eu,
    output logic             Lb,
    output logic             Lo,
    output logic             hlt
);

    logic       hlt_q;
    logic       hlt_d;
    logic       halt_req;
    logic       freeze;
    ctrl_word_t ctrl;

    contador_anel u_anel (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .freeze  (freeze),
        .t_state (t_state)
    );

    // Halt flag register; reset clears it even while halted
    always_ff @(posedge clk) begin
        if (rst) begin
            hlt_q <= 1'b0;
        end else begin
            hlt_q <= hlt_d;
        end
    end

    // Halt request at T4 of HLT also freezes the ring on that same edge so
    // the T-state parks at T4 rather than slipping to T5.
    always_comb begin
        halt_req = run && !hlt_q && (t_state == T4) && (opcode == OPC_W'(OP_HLT));
        hlt_d    = hlt_q | halt_req;
        freeze   = hlt_q | halt_req;
    end

    // Control-word decode; all zero during reset, while paused or halted
    always_comb begin
        ctrl = '0;
        if (!rst && run && !hlt_q) begin
            case (t_state)
                T1: begin
                    ctrl[CW_EP] = 1'b1;
                    ctrl[CW_LM] = 1'b1;
                end
                T2: begin
                    ctrl[CW_CP] = 1'b1;
                end
                T3: begin
                    ctrl[CW_CE] = 1'b1;
                    ctrl[CW_LI] = 1'b1;
                end
                T4: begin
                    if (opcode == OPC_W'(OP_LDA) || opcode == OPC_W'(OP_ADD) ||
                        opcode == OPC_W'(OP_SUB)) begin
                        ctrl[CW_EI] = 1'b1;
                        ctrl[CW_LM] = 1'b1;
                    end else if (opcode == OPC_W'(OP_OUT)) begin
                        ctrl[CW_EA] = 1'b1;
                        ctrl[CW_LO] = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OPC_W'(OP_LDA)) begin
                        ctrl[CW_CE] = 1'b1;
                        ctrl[CW_LA] = 1'b1;
                    end else if (opcode == OPC_W'(OP_ADD) || opcode == OPC_W'(OP_SUB)) begin
                        ctrl[CW_CE] = 1'b1;
                        ctrl[CW_LB] = 1'b1;
                    end
                end
                T6: begin
                    // Only ADD/SUB let the ALU drive the bus; Su only for SUB
                    if (opcode == OPC_W'(OP_ADD) || opcode == OPC_W'(OP_SUB)) begin
                        ctrl[CW_EU] = 1'b1;
                        ctrl[CW_LA] = 1'b1;
                        ctrl[CW_SU] = (opcode == OPC_W'(OP_SUB));
                    end
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign Cp  = ctrl[CW_CP];
    assign Ep  = ctrl[CW_EP];
    assign Lm  = ctrl[CW_LM];
    assign CE  = ctrl[CW_CE];
    assign Li  = ctrl[CW_LI];
    assign Ei  = ctrl[CW_EI];
    assign La  = ctrl[CW_LA];
    assign Ea  = ctrl[CW_EA];
    assign Su  = ctrl[CW_SU];
    assign Eu  = ctrl[CW_EU];
    assign Lb  = ctrl[CW_LB];
    assign Lo  = ctrl[CW_LO];
    assign hlt = hlt_q;

endmodule

// File: tb/tb_controlador_sequenciador.sv
// Directed bench for controlador_sequenciador. The driver applies one input
// vector per cycle and queues the hand-computed outputs for that cycle; the
// monitor pops and compares independently.
module tb_controlador_sequenciador;

    // Expected control word bits, MSB first: Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo
    localparam logic [11:0] B_CP = 12'b1000_0000_0000;
    localparam logic [11:0] B_EP = 12'b0100_0000_0000;
    localparam logic [11:0] B_LM = 12'b0010_0000_0000;
    localparam logic [11:0] B_CE = 12'b0001_0000_0000;
    localparam logic [11:0] B_LI = 12'b0000_1000_0000;
    localparam logic [11:0] B_EI = 12'b0000_0100_0000;
    localparam logic [11:0] B_LA = 12'b0000_0010_0000;
    localparam logic [11:0] B_EA = 12'b0000_0001_0000;
    localparam logic [11:0] B_SU = 12'b0000_0000_1000;
    localparam logic [11:0] B_EU = 12'b0000_0000_0100;
    localparam logic [11:0] B_LB = 12'b0000_0000_0010;
    localparam logic [11:0] B_LO = 12'b0000_0000_0001;
    localparam logic [11:0] NONE = 12'b0;

    localparam logic [5:0] S1 = 6'b000001;
    localparam logic [5:0] S2 = 6'b000010;
    localparam logic [5:0] S3 = 6'b000100;
    localparam logic [5:0] S4 = 6'b001000;
    localparam logic [5:0] S5 = 6'b010000;
    localparam logic [5:0] S6 = 6'b100000;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, hlt;

    logic [18:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    controlador_sequenciador #(.OPC_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .opcode  (opcode),
        .t_state (t_state),
        .Cp      (Cp),
        .Ep      (Ep),
        .Lm      (Lm),
        .CE      (CE),
        .Li      (Li),
        .Ei      (Ei),
        .La      (La),
        .Ea      (Ea),
        .Su      (Su),
        .Eu      (Eu),
        .Lb      (Lb),
        .Lo      (Lo),
        .hlt     (hlt)
    );

    // Clock and initial input values
    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        run    = 1'b0;
        opcode = 4'h0;
        forever #5 clk = ~clk;
    end

    // One cycle of stimulus; outputs for this cycle are queued when chk=1
    task automatic step(input logic r, input logic rn, input logic [3:0] op,
                        input logic chk, input logic [5:0] et, input logic eh,
                        input logic [11:0] ec, input string nm);
        @(negedge clk);
        rst    = r;
        run    = rn;
        opcode = op;
        if (chk) begin
            exp_q.push_back({et, eh, ec});
            name_q.push_back(nm);
        end
    endtask

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    endtask

    // Monitor: compares the DUT outputs against the oldest queued expectation
    initial begin
        logic [18:0] e;
        string       nm;
        logic [11:0] act_ctrl;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act_ctrl = {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo};
                check({nm, ".t_state"}, {6'b0, t_state}, {6'b0, e[18:13]});
                check({nm, ".hlt"}, {11'b0, hlt}, {11'b0, e[12]});
                check({nm, ".ctrl"}, act_ctrl, e[11:0]);
            end
        end
    end

    // Directed stimulus
    initial begin
        int wait_cycles;
        // Reset
        step(1, 1, 4'h0, 0, S1, 0, NONE, "rst0");
        step(1, 1, 4'h0, 1, S1, 0, NONE, "rst_hold");
        // LDA full cycle and wrap
        step(0, 1, 4'h0, 1, S1, 0, B_EP | B_LM, "lda_t1");
        step(0, 1, 4'h0, 1, S2, 0, B_CP,        "lda_t2");
        step(0, 1, 4'h0, 1, S3, 0, B_CE | B_LI, "lda_t3");
        step(0, 1, 4'h0, 1, S4, 0, B_EI | B_LM, "lda_t4");
        step(0, 1, 4'h0, 1, S5, 0, B_CE | B_LA, "lda_t5");
        step(0, 1, 4'h0, 1, S6, 0, NONE,        "lda_t6");
        // SUB full cycle
        step(0, 1, 4'h2, 1, S1, 0, B_EP | B_LM, "sub_t1");
        step(0, 1, 4'h2, 1, S2, 0, B_CP,        "sub_t2");
        step(0, 1, 4'h2, 1, S3, 0, B_CE | B_LI, "sub_t3");
        step(0, 1, 4'h2, 1, S4, 0, B_EI | B_LM, "sub_t4");
        step(0, 1, 4'h2, 1, S5, 0, B_CE | B_LB, "sub_t5");
        step(0, 1, 4'h2, 1, S6, 0, B_EU | B_LA | B_SU, "sub_t6");
        // ADD full cycle: T6 without Su
        step(0, 1, 4'h1, 1, S1, 0, B_EP | B_LM, "add_t1");
        step(0, 1, 4'h1, 1, S2, 0, B_CP,        "add_t2");
        step(0, 1, 4'h1, 1, S3, 0, B_CE | B_LI, "add_t3");
        step(0, 1, 4'h1, 1, S4, 0, B_EI | B_LM, "add_t4");
        step(0, 1, 4'h1, 1, S5, 0, B_CE | B_LB, "add_t5");
        step(0, 1, 4'h1, 1, S6, 0, B_EU | B_LA, "add_t6");
        // ADD paused for 3 cycles at T5
        step(0, 1, 4'h1, 1, S1, 0, B_EP | B_LM, "pause_t1");
        step(0, 1, 4'h1, 1, S2, 0, B_CP,        "pause_t2");
        step(0, 1, 4'h1, 1, S3, 0, B_CE | B_LI, "pause_t3");
        step(0, 1, 4'h1, 1, S4, 0, B_EI | B_LM, "pause_t4");
        for (int i = 0; i < 3; i++) step(0, 0, 4'h1, 1, S5, 0, NONE, "paused_t5");
        step(0, 1, 4'h1, 1, S5, 0, B_CE | B_LB, "resume_t5");
        step(0, 1, 4'h1, 1, S6, 0, B_EU | B_LA, "resume_t6");
        // SUB interrupted by reset at T5
        step(0, 1, 4'h2, 1, S1, 0, B_EP | B_LM, "subrst_t1");
        step(0, 1, 4'h2, 1, S2, 0, B_CP,        "subrst_t2");
        step(0, 1, 4'h2, 1, S3, 0, B_CE | B_LI, "subrst_t3");
        step(0, 1, 4'h2, 1, S4, 0, B_EI | B_LM, "subrst_t4");
        step(1, 1, 4'h2, 1, S5, 0, NONE,        "subrst_at_t5");
        step(1, 1, 4'h2, 1, S1, 0, NONE,        "subrst_hold");
        // Undefined opcode 0111 runs as NOP; opcode noise during fetch ignored
        step(0, 1, 4'hF, 1, S1, 0, B_EP | B_LM, "nop_t1");
        step(0, 1, 4'h2, 1, S2, 0, B_CP,        "nop_t2");
        step(0, 1, 4'hE, 1, S3, 0, B_CE | B_LI, "nop_t3");
        step(0, 1, 4'h7, 1, S4, 0, NONE,        "nop_t4");
        step(0, 1, 4'h7, 1, S5, 0, NONE,        "nop_t5");
        step(0, 1, 4'h7, 1, S6, 0, NONE,        "nop_t6");
        // OUT after a normal fetch
        step(0, 1, 4'hF, 1, S1, 0, B_EP | B_LM, "out_t1");
        step(0, 1, 4'h0, 1, S2, 0, B_CP,        "out_t2");
        step(0, 1, 4'h2, 1, S3, 0, B_CE | B_LI, "out_t3");
        step(0, 1, 4'hE, 1, S4, 0, B_EA | B_LO, "out_t4");
        step(0, 1, 4'hE, 1, S5, 0, NONE,        "out_t5");
        step(0, 1, 4'hE, 1, S6, 0, NONE,        "out_t6");
        // HLT: flag sets after T4, machine parks at T4 until reset
        step(0, 1, 4'hF, 1, S1, 0, B_EP | B_LM, "hlt_t1");
        step(0, 1, 4'hF, 1, S2, 0, B_CP,        "hlt_t2");
        step(0, 1, 4'hF, 1, S3, 0, B_CE | B_LI, "hlt_t3");
        step(0, 1, 4'hF, 1, S4, 0, NONE,        "hlt_t4");
        for (int i = 0; i < 20; i++) begin
            step(0, (i % 5) != 3, (i % 2 == 1) ? 4'hF : 4'h1, 1, S4, 1, NONE, "halted");
        end
        step(1, 1, 4'h0, 1, S4, 1, NONE,        "halt_rst");
        step(0, 1, 4'h0, 1, S1, 0, B_EP | B_LM, "after_halt_t1");
        step(0, 1, 4'h0, 1, S2, 0, B_CP,        "after_halt_t2");
        // Drain, bounded
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
